// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder for a pipeline memory stage.
// Accepts one request at a time (valid/ready), answers after exactly LATENCY
// cycles with a registered response held until the requester consumes it.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_addr             byte address; must be word aligned and below 4*DEPTH
//   req_write            1 = store, 0 = load
//   req_strobe           per-byte-lane write enables for stores
//   req_wdata            store data
//   resp_valid/resp_ready response handshake
//   resp_rdata           load data (0 for stores and errors)
//   resp_err             misaligned or out-of-range request
//   busy                 transaction in flight (WAIT or RESP)
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic [31:0] lat_addr;
  logic        lat_write;
  logic [3:0]  lat_strobe;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   acc_addr;
  logic          acc_write;
  logic [3:0]    acc_strobe;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  // Reset holds the FSM in IDLE, so ready must also be gated by reset itself.
  assign req_ready  = (state == IDLE) && !reset;
  assign busy       = (state == WAIT) || (state == RESP);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With LATENCY=1 the access happens on the acceptance edge, before the
  // request registers hold anything, so the live inputs feed the access path.
  always_comb begin
    acc_addr   = lat_addr;
    acc_write  = lat_write;
    acc_strobe = lat_strobe;
    acc_wdata  = lat_wdata;
    if (state == IDLE) begin
      acc_addr   = req_addr;
      acc_write  = req_write;
      acc_strobe = req_strobe;
      acc_wdata  = req_wdata;
    end
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state == IDLE)
      enter_resp = accept && (LATENCY == 1);
    else if (state == WAIT)
      enter_resp = (cnt == 4'd0);
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
  assign acc_idx = acc_addr[AW+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= (LATENCY == 1) ? RESP : WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0)
            state <= RESP;
          else
            cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || acc_write) ? '0 : mem[acc_idx];
      end
    end
  end

  // Request capture; contents only matter while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr   <= req_addr;
      lat_write  <= req_write;
      lat_strobe <= req_strobe;
      lat_wdata  <= req_wdata;
    end
  end

  // Storage is never reset; a store is committed only on the edge entering RESP,
  // so a reset while waiting discards it.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_strobe[i])
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words held; power of two, at least 4.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid; at least 1, at most 15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  memory-stage request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_strobe  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  requester consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.
REQ-015 busy  output  1  request accepted and not yet retired; drives pipeline stall.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in WAIT and RESP.
REQ-018 A request SHALL be accepted when req_valid and req_ready are both 1 at a posedge; at that edge addr, write, strobe and wdata SHALL be latched.
- Later input changes SHALL NOT affect the transaction.
REQ-019 Latency SHALL be exact: for acceptance at edge T, resp_valid SHALL first be 1 in the cycle after edge T+LATENCY-1.
- LATENCY=1: IDLE goes directly to RESP.
- Otherwise: IDLE goes to WAIT, with a down-counter loaded with LATENCY-2; WAIT goes to RESP on the edge where the counter is 0.
REQ-020 The memory access SHALL be performed on the edge entering RESP; resp_rdata and resp_err SHALL be registered at that edge.
REQ-021 Error condition: resp_err=1 when latched addr[1:0] is nonzero or the word index addr[31:2] is at least DEPTH.
- On error, no memory write occurs and resp_rdata=0.
REQ-022 A valid store SHALL update only the byte lanes whose strobe bit is 1.
- strobe=0 still completes normally with resp_err=0.
REQ-023 A valid load SHALL return the full 32-bit word at the word index, ignoring strobe.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until a cycle with resp_ready=1; that edge returns to IDLE.
REQ-025 resp_ready while resp_valid=0 SHALL be ignored; a req_valid present outside IDLE SHALL NOT be accepted or lost: it is accepted on the first IDLE cycle.
REQ-026 No back-to-back overlap: the minimum request-to-request spacing is LATENCY+1 cycles.
REQ-027 A load to a word stored by the immediately previous transaction SHALL return the updated data.

Reset
REQ-028 While reset=1, asynchronously: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=0.
- req_ready returns to 1 in the first cycle after deassertion.
REQ-029 Reset during WAIT SHALL discard the transaction: no memory write, no response.
REQ-030 Memory contents SHALL NOT be cleared by reset; words not yet written read as unspecified.

Verification
REQ-031 Sequence: reset, then store addr 0x10 wdata 0xDEADBEEF strobe 0xF, then load 0x10, LATENCY=2, resp_ready=1.
- Each resp_valid arrives exactly 2 cycles after acceptance.
- Load returns 0xDEADBEEF, err=0.
REQ-032 After REQ-031, store 0x10 wdata 0x000000AA strobe 0x1, then load 0x10 -> returns 0xDEADBEAA.
REQ-033 Load at 0x13 -> resp_err=1, rdata=0. Store at byte address 4*DEPTH -> resp_err=1, and a subsequent load of word 0 is unchanged.
REQ-034 Hold resp_ready=0 for 5 cycles after resp_valid.
- resp_valid and data stay stable, req_ready=0, and a waiting req_valid is not accepted.
- Raise resp_ready: the request is accepted on the first IDLE cycle.
REQ-035 Assert reset one cycle after accepting store 0x20 wdata 0x12345678 with LATENCY=3, then load 0x20 -> prior contents, no response to the aborted store.
REQ-036 LATENCY=1 build: store then load at 0x8 -> each response 1 cycle after acceptance; load returns the stored word.
